// File: rtl/dp_sequencer_if.sv
// Command, datapath-control and memory handshake bundle for dp_sequencer.
// The err line exists only when DP_SEQ_TIMEOUT_EN is defined.
interface dp_sequencer_if #(
  parameter int size = 32
);
  localparam int AW = $clog2(size);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [3:0]    cmd_sel;
  logic          cmd_use_imm;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic [AW-1:0] cmd_rd;
  logic          we;
  logic          MB_select;
  logic          MD_select;
  logic          MR_select;
  logic [3:0]    Sel;
  logic [AW-1:0] A_select;
  logic [AW-1:0] B_select;
  logic [AW-1:0] D_addr;
  logic          mem_req;
  logic          mem_we;
  logic          mem_ack;
  logic          C;
  logic          V;
  logic          N;
  logic          Z;
  logic [3:0]    flags_q;
  logic          done;
`ifdef DP_SEQ_TIMEOUT_EN
  logic          err;
`endif

  modport master (
    input  cmd_valid, cmd_op, cmd_sel, cmd_use_imm, cmd_rs1, cmd_rs2, cmd_rd,
    input  mem_ack, C, V, N, Z,
    output cmd_ready, we, MB_select, MD_select, MR_select, Sel,
    output A_select, B_select, D_addr, mem_req, mem_we, flags_q, done
`ifdef DP_SEQ_TIMEOUT_EN
    , output err
`endif
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_sel, cmd_use_imm, cmd_rs1, cmd_rs2, cmd_rd,
    output mem_ack, C, V, N, Z,
    input  cmd_ready, we, MB_select, MD_select, MR_select, Sel,
    input  A_select, B_select, D_addr, mem_req, mem_we, flags_q, done
`ifdef DP_SEQ_TIMEOUT_EN
    , input err
`endif
  );
endinterface

// File: rtl/dp_sequencer.sv
// Multi-cycle IDLE/EXEC/MEM control sequencer for the register-file/FU datapath.
// Optional memory watchdog (err pulse after TIMEOUT_CYCLES) enabled by DP_SEQ_TIMEOUT_EN.
module dp_sequencer #(
  parameter int         size    = 32,
  parameter logic [3:0] ADD_SEL = 4'd0
`ifdef DP_SEQ_TIMEOUT_EN
  , parameter int       TIMEOUT_CYCLES = 16
`endif
) (
  input logic            clk,
  input logic            reset,
  dp_sequencer_if.master bus
);
  localparam int AW = $clog2(size);
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_LINK  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [1:0]    op_r;
  logic [3:0]    sel_r;
  logic          use_imm_r;
  logic [AW-1:0] rs1_r, rs2_r, rd_r;
  logic [3:0]    flags_r;
  logic          done_r;
  logic          rd_nz_s;
  logic          ready_s, accept_s, retire_s, flags_ld_s;
  logic          we_s, mb_s, md_s, mr_s, req_s, mwe_s;
  logic [3:0]    sel_s;
  logic [AW-1:0] a_s, b_s, d_s;

`ifdef DP_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_r;
  logic          err_r;
  logic          timeout_s;
  logic          cnt_last_s;

  assign cnt_last_s = (cnt_r == CW'(TIMEOUT_CYCLES - 1));
`endif

  // x0 is hardwired, so writes to it are dropped but the command still retires.
  assign rd_nz_s = (rd_r != {AW{1'b0}});

  // Next-state and per-state control decode.
  always_comb begin
    state_nxt_s = state_r;
    ready_s     = 1'b0;
    accept_s    = 1'b0;
    retire_s    = 1'b0;
    flags_ld_s  = 1'b0;
    we_s        = 1'b0;
    mb_s        = 1'b0;
    md_s        = 1'b0;
    mr_s        = 1'b0;
    req_s       = 1'b0;
    mwe_s       = 1'b0;
    sel_s       = 4'd0;
    a_s         = {AW{1'b0}};
    b_s         = {AW{1'b0}};
    d_s         = {AW{1'b0}};
`ifdef DP_SEQ_TIMEOUT_EN
    timeout_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        ready_s = !reset;
        if (bus.cmd_valid && ready_s) begin
          accept_s = 1'b1;
          if (bus.cmd_op == OP_LOAD || bus.cmd_op == OP_STORE) begin
            state_nxt_s = ST_MEM;
          end else begin
            state_nxt_s = ST_EXEC;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        d_s         = rd_r;
        we_s        = rd_nz_s;
        retire_s    = 1'b1;
        state_nxt_s = ST_IDLE;
        if (op_r == OP_LINK) begin
          mr_s = 1'b1;
        end else begin
          a_s        = rs1_r;
          b_s        = rs2_r;
          mb_s       = use_imm_r;
          sel_s      = sel_r;
          flags_ld_s = 1'b1;
        end
      end
      ST_MEM: begin
        a_s   = rs1_r;
        b_s   = rs2_r;
        mb_s  = 1'b1;
        sel_s = ADD_SEL;
        req_s = 1'b1;
        mwe_s = (op_r == OP_STORE);
        if (bus.mem_ack) begin
          retire_s    = 1'b1;
          state_nxt_s = ST_IDLE;
          // Load write-back rides on the ack cycle, when Data_in is valid.
          if (op_r == OP_LOAD) begin
            md_s = 1'b1;
            d_s  = rd_r;
            we_s = rd_nz_s;
          end else begin
            md_s = 1'b0;
          end
        end else begin
`ifdef DP_SEQ_TIMEOUT_EN
          if (cnt_last_s) begin
            timeout_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_MEM;
          end
`else
          state_nxt_s = ST_MEM;
`endif
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, latched command, captured flags and retire pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      op_r      <= 2'd0;
      sel_r     <= 4'd0;
      use_imm_r <= 1'b0;
      rs1_r     <= {AW{1'b0}};
      rs2_r     <= {AW{1'b0}};
      rd_r      <= {AW{1'b0}};
      flags_r   <= 4'd0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= retire_s;
      if (accept_s) begin
        op_r      <= bus.cmd_op;
        sel_r     <= bus.cmd_sel;
        use_imm_r <= bus.cmd_use_imm;
        rs1_r     <= bus.cmd_rs1;
        rs2_r     <= bus.cmd_rs2;
        rd_r      <= bus.cmd_rd;
      end
      if (flags_ld_s) begin
        flags_r <= {bus.C, bus.V, bus.N, bus.Z};
      end
    end
  end

`ifdef DP_SEQ_TIMEOUT_EN
  // Memory watchdog: counts unacknowledged MEM cycles and flags expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
      err_r <= 1'b0;
    end else begin
      err_r <= timeout_s;
      if (accept_s) begin
        cnt_r <= {CW{1'b0}};
      end else if (state_r == ST_MEM && !bus.mem_ack) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign bus.err = err_r;
`endif

  assign bus.cmd_ready = ready_s;
  assign bus.we        = we_s;
  assign bus.MB_select = mb_s;
  assign bus.MD_select = md_s;
  assign bus.MR_select = mr_s;
  assign bus.Sel       = sel_s;
  assign bus.A_select  = a_s;
  assign bus.B_select  = b_s;
  assign bus.D_addr    = d_s;
  assign bus.mem_req   = req_s;
  assign bus.mem_we    = mwe_s;
  assign bus.flags_q   = flags_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: directed scenarios plus randomized commands
// checked against a phase-level reference model of the sequencer's outputs.
module tb_dp_sequencer;
  localparam int         SIZE    = 32;
  localparam int         AW      = $clog2(SIZE);
  localparam logic [3:0] ADD_SEL = 4'hA;
  localparam int         TO      = 4;

  localparam int PH_IDLE = 0;
  localparam int PH_EXEC = 1;
  localparam int PH_WAIT = 2;
  localparam int PH_ACK  = 3;

  typedef struct packed {
    logic [1:0]    op;
    logic [3:0]    sel;
    logic          imm;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
  } cmd_t;

  typedef struct packed {
    logic          ready;
    logic          we;
    logic          mb;
    logic          md;
    logic          mr;
    logic [3:0]    sel;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] d;
    logic          req;
    logic          mwe;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset;
  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_flags = 4'd0;

  always #5 clk = ~clk;

  dp_sequencer_if #(.size(SIZE)) bus ();

  dp_sequencer #(
    .size(SIZE),
    .ADD_SEL(ADD_SEL)
`ifdef DP_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Expected control outputs for a command in a given phase, from the command's rules.
  function automatic ctrl_t model(input cmd_t c, input int ph);
    ctrl_t e;
    logic  writes;
    e      = {$bits(ctrl_t){1'b0}};
    writes = (c.rd != 0);
    case (ph)
      PH_IDLE: e.ready = 1'b1;
      PH_EXEC: begin
        e.d  = c.rd;
        e.we = writes;
        if (c.op == 2'd3) begin
          e.mr = 1'b1;
        end else begin
          e.a   = c.rs1;
          e.b   = c.rs2;
          e.mb  = c.imm;
          e.sel = c.sel;
        end
      end
      PH_WAIT, PH_ACK: begin
        e.a   = c.rs1;
        e.b   = c.rs2;
        e.mb  = 1'b1;
        e.sel = ADD_SEL;
        e.req = 1'b1;
        e.mwe = (c.op == 2'd2);
        if (ph == PH_ACK && c.op == 2'd1) begin
          e.md = 1'b1;
          e.d  = c.rd;
          e.we = writes;
        end
      end
      default: e = {$bits(ctrl_t){1'b0}};
    endcase
    return e;
  endfunction

  function automatic ctrl_t observe();
    ctrl_t o;
    o.ready = bus.cmd_ready;
    o.we    = bus.we;
    o.mb    = bus.MB_select;
    o.md    = bus.MD_select;
    o.mr    = bus.MR_select;
    o.sel   = bus.Sel;
    o.a     = bus.A_select;
    o.b     = bus.B_select;
    o.d     = bus.D_addr;
    o.req   = bus.mem_req;
    o.mwe   = bus.mem_we;
    return o;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op  = 2'($urandom_range(0, 3));
    c.sel = 4'($urandom);
    c.imm = 1'($urandom);
    c.rs1 = AW'($urandom);
    c.rs2 = AW'($urandom);
    c.rd  = AW'($urandom);
    return c;
  endfunction

  task automatic drive_cmd(input logic valid, input cmd_t c);
    bus.cmd_valid   = valid;
    bus.cmd_op      = c.op;
    bus.cmd_sel     = c.sel;
    bus.cmd_use_imm = c.imm;
    bus.cmd_rs1     = c.rs1;
    bus.cmd_rs2     = c.rs2;
    bus.cmd_rd      = c.rd;
  endtask

  task automatic set_flags(input logic [3:0] f);
    {bus.C, bus.V, bus.N, bus.Z} = f;
  endtask

  task automatic test_reset();
    ctrl_t o;
    reset       = 1'b1;
    bus.mem_ack = 1'b0;
    drive_cmd(1'b0, rand_cmd());
    set_flags(4'd0);
    repeat (2) @(negedge clk);
    #1;
    o = observe();
    checks++;
    if (o !== {$bits(ctrl_t){1'b0}}) begin
      failures++;
      $display("FAIL reset_ctrl: got %h expected 0", o);
    end
    checks++;
    if ({bus.done, bus.flags_q} !== 5'b0) begin
      failures++;
      $display("FAIL reset_state: got done=%b flags_q=%h expected 0", bus.done, bus.flags_q);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    o = observe();
    checks++;
    if (o !== model(rand_cmd(), PH_IDLE)) begin
      failures++;
      $display("FAIL reset_release: got %h expected %h", o, model(rand_cmd(), PH_IDLE));
    end
  endtask

  task automatic test_alu();
    cmd_t       c;
    logic [3:0] f;
    c     = rand_cmd();
    c.op  = 2'd0;
    c.sel = 4'd0;
    c.imm = 1'b0;
    c.rs1 = AW'(1);
    c.rs2 = AW'(2);
    c.rd  = AW'(3);
    @(negedge clk);
    drive_cmd(1'b1, c);
    #1;
    checks++;
    if (observe() !== model(c, PH_IDLE)) begin
      failures++;
      $display("FAIL alu_accept: got %h expected %h", observe(), model(c, PH_IDLE));
    end
    @(negedge clk);
    drive_cmd(1'b0, rand_cmd());
    f = 4'($urandom);
    set_flags(f);
    #1;
    checks++;
    if ({observe(), bus.done} !== {model(c, PH_EXEC), 1'b0}) begin
      failures++;
      $display("FAIL alu_exec: got %h/%b expected %h/0", observe(), bus.done, model(c, PH_EXEC));
    end
    exp_flags = f;
    @(negedge clk);
    set_flags(~f);
    #1;
    checks++;
    if ({bus.done, bus.flags_q} !== {1'b1, exp_flags}) begin
      failures++;
      $display("FAIL alu_done: got done=%b flags_q=%h expected 1/%h", bus.done, bus.flags_q, exp_flags);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL alu_done_once: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_load();
    cmd_t c;
    c     = rand_cmd();
    c.op  = 2'd1;
    c.rs1 = AW'(4);
    c.rd  = AW'(5);
    @(negedge clk);
    drive_cmd(1'b1, c);
    #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_cmd(1'b0, rand_cmd());
      set_flags(4'($urandom));
      bus.mem_ack = (k == 3);
      #1;
      checks++;
      if ({observe(), bus.done} !== {model(c, (k == 3) ? PH_ACK : PH_WAIT), 1'b0}) begin
        failures++;
        $display("FAIL load_mem%0d: got %h/%b expected %h/0", k, observe(), bus.done,
                 model(c, (k == 3) ? PH_ACK : PH_WAIT));
      end
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    checks++;
    if ({observe(), bus.done, bus.flags_q} !== {model(c, PH_IDLE), 1'b1, exp_flags}) begin
      failures++;
      $display("FAIL load_done: got %h/%b/%h expected %h/1/%h", observe(), bus.done, bus.flags_q,
               model(c, PH_IDLE), exp_flags);
    end
  endtask

  task automatic test_store();
    cmd_t c;
    c     = rand_cmd();
    c.op  = 2'd2;
    c.rs1 = AW'(6);
    c.rs2 = AW'(7);
    c.rd  = AW'(8);
    @(negedge clk);
    drive_cmd(1'b1, c);
    #1;
    @(negedge clk);
    drive_cmd(1'b0, rand_cmd());
    bus.mem_ack = 1'b1;
    #1;
    checks++;
    if ({observe(), bus.we} !== {model(c, PH_ACK), 1'b0}) begin
      failures++;
      $display("FAIL store_mem: got %h we=%b expected %h we=0", observe(), bus.we, model(c, PH_ACK));
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    checks++;
    if ({observe(), bus.done} !== {model(c, PH_IDLE), 1'b1}) begin
      failures++;
      $display("FAIL store_done: got %h/%b expected %h/1", observe(), bus.done, model(c, PH_IDLE));
    end
  endtask

  task automatic test_back_to_back();
    cmd_t       c1, c2;
    logic [3:0] f;
    c1    = rand_cmd();
    c1.op = 2'd3;
    c1.rd = AW'(1);
    c2    = rand_cmd();
    c2.op = 2'd0;
    c2.rd = AW'(0);
    @(negedge clk);
    drive_cmd(1'b1, c1);
    #1;
    @(negedge clk);
    drive_cmd(1'b0, rand_cmd());
    set_flags(~exp_flags);
    #1;
    checks++;
    if (observe() !== model(c1, PH_EXEC)) begin
      failures++;
      $display("FAIL link_exec: got %h expected %h", observe(), model(c1, PH_EXEC));
    end
    @(negedge clk);
    drive_cmd(1'b1, c2);
    #1;
    checks++;
    if ({observe(), bus.done, bus.flags_q} !== {model(c2, PH_IDLE), 1'b1, exp_flags}) begin
      failures++;
      $display("FAIL link_done_accept: got %h/%b/%h expected %h/1/%h", observe(), bus.done,
               bus.flags_q, model(c2, PH_IDLE), exp_flags);
    end
    @(negedge clk);
    drive_cmd(1'b0, rand_cmd());
    f = 4'($urandom);
    set_flags(f);
    #1;
    checks++;
    if ({observe(), bus.done} !== {model(c2, PH_EXEC), 1'b0}) begin
      failures++;
      $display("FAIL alu_x0_exec: got %h/%b expected %h/0", observe(), bus.done, model(c2, PH_EXEC));
    end
    exp_flags = f;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.done, bus.we, bus.flags_q} !== {1'b1, 1'b0, exp_flags}) begin
      failures++;
      $display("FAIL alu_x0_done: got done=%b we=%b flags_q=%h expected 1/0/%h", bus.done, bus.we,
               bus.flags_q, exp_flags);
    end
  endtask

  task automatic test_reset_mid_load();
    cmd_t c;
    c    = rand_cmd();
    c.op = 2'd1;
    c.rd = AW'($urandom_range(1, SIZE - 1));
    @(negedge clk);
    drive_cmd(1'b1, c);
    #1;
    repeat (2) @(negedge clk);
    drive_cmd(1'b0, rand_cmd());
    #1;
    checks++;
    if (observe() !== model(c, PH_WAIT)) begin
      failures++;
      $display("FAIL abort_pre: got %h expected %h", observe(), model(c, PH_WAIT));
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({observe(), bus.done} !== {($bits(ctrl_t) + 1){1'b0}}) begin
      failures++;
      $display("FAIL abort_ctrl: got %h/%b expected 0", observe(), bus.done);
    end
    exp_flags = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_ack = 1'($urandom);
      #1;
      checks++;
      if ({observe(), bus.done, bus.flags_q} !== {model(c, PH_IDLE), 1'b0, exp_flags}) begin
        failures++;
        $display("FAIL abort_after%0d: got %h/%b/%h expected %h/0/%h", k, observe(), bus.done,
                 bus.flags_q, model(c, PH_IDLE), exp_flags);
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_random();
    cmd_t       c;
    logic [3:0] f;
    logic       pend_done;
    int         delay, gap;
    pend_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      c     = rand_cmd();
      delay = $urandom_range(0, TO - 1);
      gap   = $urandom_range(0, 2);
      @(negedge clk);
      drive_cmd(1'b1, c);
      bus.mem_ack = 1'($urandom);
      #1;
      checks++;
      if ({observe(), bus.done, bus.flags_q} !== {model(c, PH_IDLE), pend_done, exp_flags}) begin
        failures++;
        $display("FAIL rnd_accept%0d: got %h/%b/%h expected %h/%b/%h", i, observe(), bus.done,
                 bus.flags_q, model(c, PH_IDLE), pend_done, exp_flags);
      end
      if (c.op == 2'd0 || c.op == 2'd3) begin
        @(negedge clk);
        drive_cmd(1'b0, rand_cmd());
        bus.mem_ack = 1'($urandom);
        f = 4'($urandom);
        set_flags(f);
        #1;
        checks++;
        if ({observe(), bus.done} !== {model(c, PH_EXEC), 1'b0}) begin
          failures++;
          $display("FAIL rnd_exec%0d: got %h/%b expected %h/0", i, observe(), bus.done,
                   model(c, PH_EXEC));
        end
        if (c.op == 2'd0) exp_flags = f;
      end else begin
        for (int k = 0; k <= delay; k++) begin
          @(negedge clk);
          drive_cmd(1'b0, rand_cmd());
          set_flags(4'($urandom));
          bus.mem_ack = (k == delay);
          #1;
          checks++;
          if ({observe(), bus.done} !== {model(c, (k == delay) ? PH_ACK : PH_WAIT), 1'b0}) begin
            failures++;
            $display("FAIL rnd_mem%0d_%0d: got %h/%b expected %h/0", i, k, observe(), bus.done,
                     model(c, (k == delay) ? PH_ACK : PH_WAIT));
          end
        end
      end
      pend_done = 1'b1;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        drive_cmd(1'b0, rand_cmd());
        bus.mem_ack = 1'($urandom);
        #1;
        checks++;
        if ({observe(), bus.done, bus.flags_q} !== {model(c, PH_IDLE), pend_done, exp_flags}) begin
          failures++;
          $display("FAIL rnd_gap%0d: got %h/%b/%h expected %h/%b/%h", i, observe(), bus.done,
                   bus.flags_q, model(c, PH_IDLE), pend_done, exp_flags);
        end
        pend_done = 1'b0;
      end
    end
    @(negedge clk);
    drive_cmd(1'b0, rand_cmd());
    bus.mem_ack = 1'b0;
    #1;
    checks++;
    if (bus.done !== pend_done) begin
      failures++;
      $display("FAIL rnd_last_done: got %b expected %b", bus.done, pend_done);
    end
  endtask

`ifdef DP_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    cmd_t c;
    c    = rand_cmd();
    c.op = 2'd1;
    c.rd = AW'(9);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      drive_cmd(1'b1, c);
      bus.mem_ack = 1'b0;
      #1;
      for (int k = 0; k < TO; k++) begin
        @(negedge clk);
        drive_cmd(1'b0, rand_cmd());
        bus.mem_ack = (pass == 1) && (k == TO - 1);
        #1;
        checks++;
        if ({observe(), bus.err, bus.done} !==
            {model(c, bus.mem_ack ? PH_ACK : PH_WAIT), 2'b00}) begin
          failures++;
          $display("FAIL to_mem%0d_%0d: got %h/%b/%b expected %h/0/0", pass, k, observe(), bus.err,
                   bus.done, model(c, bus.mem_ack ? PH_ACK : PH_WAIT));
        end
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      checks++;
      if ({observe(), bus.err, bus.done} !== {model(c, PH_IDLE), (pass == 0), (pass == 1)}) begin
        failures++;
        $display("FAIL to_end%0d: got %h err=%b done=%b expected %h err=%b done=%b", pass, observe(),
                 bus.err, bus.done, model(c, PH_IDLE), (pass == 0), (pass == 1));
      end
      @(negedge clk);
      #1;
      checks++;
      if ({bus.err, bus.done} !== 2'b00) begin
        failures++;
        $display("FAIL to_pulse%0d: got err=%b done=%b expected 0/0", pass, bus.err, bus.done);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_mid_load();
`ifdef DP_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Multi-cycle control sequencer for the register-file/FU datapath.
- Accepts one macro-command per handshake: ALU, LOAD, STORE or LINK.
- Drives the datapath control inputs (we, MB/MD/MR selects, Sel, register addresses) cycle by cycle.
- Handles the memory request/acknowledge handshake for loads and stores.
- Sits between instruction decode/issue and the datapath; decode stays combinational, and all timing lives here.

Parameters:
- size, 32, datapath width; register address width is $clog2(size).
- ADD_SEL, 4'd0, FU Sel code used for the address add (rs1 + constant) on LOAD/STORE.
- TIMEOUT_CYCLES, 16, memory watchdog limit; used only with DP_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  command: 0=ALU, 1=LOAD, 2=STORE, 3=LINK.
- cmd_sel  in  4  FU Sel code for ALU commands.
- cmd_use_imm  in  1  ALU only: B operand is the constant instead of rs2.
- cmd_rs1  in  $clog2(size)  source register A.
- cmd_rs2  in  $clog2(size)  source register B; also the store-data register.
- cmd_rd  in  $clog2(size)  destination register.
- we  out  1  register file write enable.
- MB_select  out  1  1 selects Constant_in as the FU B operand.
- MD_select  out  1  1 selects memory Data_in onto the D bus.
- MR_select  out  1  1 selects PC_in as the register write data.
- Sel  out  4  FU operation.
- A_select  out  $clog2(size)  register A read address.
- B_select  out  $clog2(size)  register B read address.
- D_addr  out  $clog2(size)  register write address.
- mem_req  out  1  memory request; Addr_out/Data_out are valid while high.
- mem_we  out  1  store when high, load when low; qualified by mem_req.
- mem_ack  in  1  memory completes the request this cycle; load data is valid on Data_in in this cycle.
- C, V, N, Z  in  1 each  FU flags.
- flags_q  out  4  {C,V,N,Z} captured on the last ALU execute.
- done  out  1  one-cycle pulse after a command retires.
- err  out  1  timeout pulse; exists only with DP_SEQ_TIMEOUT_EN.

Behaviour:
- States: IDLE, EXEC, MEM.
- Reset (asynchronous): state goes to IDLE immediately. Latched command is discarded. flags_q=0, done=0, err=0, counter=0.
  - All control outputs read 0 during reset; mem_req drops at once, even mid-transaction.
- IDLE:
  - cmd_ready=1 and all datapath/memory outputs are 0.
  - On cmd_valid&&cmd_ready, cmd_* fields are latched. cmd_* inputs are ignored after acceptance.
  - Next state is EXEC for ALU/LINK and MEM for LOAD/STORE.
- cmd_ready is 0 in EXEC and MEM, so at most one command is in flight.
  - Back-to-back ALU throughput is one command per 2 cycles.
- EXEC lasts exactly 1 cycle:
  - ALU: A_select=rs1, B_select=rs2, MB_select=use_imm, Sel=cmd_sel, MD_select=0, MR_select=0, D_addr=rd, we=(rd!=0). flags_q <= {C,V,N,Z} at the cycle end.
  - LINK: MR_select=1, D_addr=rd, we=(rd!=0); flags_q is unchanged.
  - Next state is IDLE, and done=1 during the following cycle.
- MEM holds until mem_ack:
  - A_select=rs1, B_select=rs2, MB_select=1, Sel=ADD_SEL, mem_req=1, mem_we=(op==STORE). These are held stable every MEM cycle.
  - In the mem_ack cycle of a LOAD only: MD_select=1, MR_select=0, D_addr=rd, we=(rd!=0). These are combinational on mem_ack.
  - STORE never asserts we.
  - mem_ack in the first MEM cycle is legal, giving a minimum of 1 MEM cycle.
  - After mem_ack, next state is IDLE and done=1 during the following cycle.
  - mem_ack outside MEM is ignored.
- rd==0 is a write to x0: the command completes normally (done pulses) and we stays 0.
- done is registered and high for exactly one cycle per retired command. The same cycle may also accept a new command, since state is IDLE.
- flags_q is updated only by ALU commands.

Optional Feature:
- Macro: DP_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on MEM entry and increments each MEM cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES, that cycle drops mem_req, suppresses we and returns to IDLE.
  - err pulses 1 cycle in the next cycle and done stays 0.
  - mem_ack in the same cycle as the limit wins: normal completion, no err.
- Undefined: no counter, no err port; MEM waits indefinitely.

Test Plan:
- Reset, then ALU sel=0 rs1=1 rs2=2 rd=3 use_imm=0 -> cmd_ready low 1 cycle; EXEC shows A_select=1 B_select=2 D_addr=3 we=1 MB_select=0; done 1 cycle later; flags_q equals FU flags.
- LOAD rs1=4 rd=5, mem_ack after 3 cycles -> mem_req=1 mem_we=0 MB_select=1 Sel=ADD_SEL for 4 cycles; we=1 MD_select=1 D_addr=5 only in the ack cycle; done next cycle.
- STORE rs1=6 rs2=7, mem_ack in the first MEM cycle -> mem_we=1 B_select=7 for 1 cycle, we never 1, done next cycle.
- LINK rd=1, then ALU rd=0 back-to-back -> first: MR_select=1 we=1 D_addr=1; second: we=0 with done still pulsing; accept occurs in the done cycle.
- Assert reset during a LOAD's 2nd MEM cycle -> mem_req and all controls 0 immediately; after release cmd_ready=1 and no done or we occurs for the aborted load.
- (DP_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4) LOAD with no ack -> mem_req high 4 cycles, err pulse, no done, no we; repeat with ack on the 4th cycle -> normal done, no err.
